// File: rtl/alu_op_decode_stage_pkg.sv
// alu_op_decode_stage_pkg: ALU op codes, MIPS opcode/funct constants and the decoded bundle
package alu_op_decode_stage_pkg;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDU = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SUBU = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_NOR  = 5'd6;
  localparam logic [4:0] ALU_SLT  = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_JR   = 5'd11;
  localparam logic [4:0] ALU_NOP  = 5'd12;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  typedef struct packed {
    logic [4:0]  alu_op;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        illegal;
  } bundle_t;
  localparam int BUNDLE_W = $bits(bundle_t);
endpackage

// File: rtl/mips_alu_op_lut.sv
// mips_alu_op_lut: combinational MIPS instruction word to ALU command bundle
module mips_alu_op_lut
  import alu_op_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output bundle_t     bundle
);
  logic [5:0] op, fn;
  logic [4:0] r_op, i_op, rd;
  logic r_ok, i_ok, i_sx, rtype, nop, ill, shift;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rtype = op == OP_RTYPE;
  assign nop = instr == 32'd0;
  assign ill = rtype ? !r_ok : !i_ok;
  assign shift = r_op == ALU_SLL || r_op == ALU_SRL || r_op == ALU_SRA;
  assign rd = ill || (rtype && r_op == ALU_JR) ? 5'd0 : rtype ? instr[15:11] : instr[20:16];
  // R-type funct lookup
  always_comb begin
    r_op = ALU_NOP;
    r_ok = 1'b1;
    case (fn)
      FN_ADD:  r_op = ALU_ADD;
      FN_ADDU: r_op = ALU_ADDU;
      FN_SUB:  r_op = ALU_SUB;
      FN_SUBU: r_op = ALU_SUBU;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_NOR:  r_op = ALU_NOR;
      FN_SLT:  r_op = ALU_SLT;
      FN_SLL:  r_op = ALU_SLL;
      FN_SRL:  r_op = ALU_SRL;
      FN_SRA:  r_op = ALU_SRA;
      FN_JR:   r_op = ALU_JR;
      default: r_ok = 1'b0;
    endcase
  end
  // I-type opcode lookup; logical immediates zero-extend
  always_comb begin
    i_op = ALU_NOP;
    i_ok = 1'b1;
    i_sx = 1'b1;
    case (op)
      OP_ADDI:  i_op = ALU_ADD;
      OP_ADDIU: i_op = ALU_ADDU;
      OP_SLTI:  i_op = ALU_SLT;
      OP_ANDI:  begin i_op = ALU_AND; i_sx = 1'b0; end
      OP_ORI:   begin i_op = ALU_OR;  i_sx = 1'b0; end
      default:  i_ok = 1'b0;
    endcase
  end
  // bundle assembly; the all-zero word is a nop rather than sll $0,$0,0
  always_comb begin
    bundle.alu_op    = ill || nop ? ALU_NOP : rtype ? r_op : i_op;
    bundle.shamt     = rtype && shift ? instr[10:6] : 5'd0;
    bundle.rs        = instr[25:21];
    bundle.rt        = instr[20:16];
    bundle.rd        = rd;
    bundle.imm       = rtype || ill ? 32'd0 : {{16{i_sx & instr[15]}}, instr[15:0]};
    bundle.use_imm   = !rtype && !ill;
    bundle.reg_write = rd != 5'd0;
    bundle.illegal   = ill;
  end
endmodule

// File: rtl/alu_op_decode_stage.sv
// alu_op_decode_stage: decode stage with 2-entry output skid buffer and illegal counter
module alu_op_decode_stage
  import alu_op_decode_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       alu_op,
  output logic [4:0]       shamt,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [31:0]      imm,
  output logic             use_imm,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  localparam bundle_t RST_B = bundle_t'({ALU_NOP, {(BUNDLE_W-5){1'b0}}});
  state_t state, nxt;
  bundle_t dec, b0, b1;
  logic acc, drn, ld0, ld1, mv;
  mips_alu_op_lut u_lut (.instr(instr), .bundle(dec));
  assign out_valid = state != EMPTY;
  assign in_ready = state != FULL;
  assign acc = in_valid && in_ready && !flush;
  assign drn = out_valid && out_ready;
  // next occupancy and buffer write enables; b0 is always the head
  always_comb begin
    ld0 = acc && (state == EMPTY || (state == ONE && drn));
    ld1 = acc && state == ONE && !drn;
    mv  = state == FULL && drn;
    nxt = flush ? EMPTY
        : ld1 ? FULL
        : state == ONE && drn && !acc ? EMPTY
        : (state == EMPTY && acc) || mv ? ONE
        : state;
  end
  // buffer, occupancy and saturating illegal counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      b0          <= RST_B;
      b1          <= RST_B;
      illegal_cnt <= '0;
    end else begin
      state <= nxt;
      if (ld0) b0 <= dec;
      else if (mv) b0 <= b1;
      if (ld1) b1 <= dec;
      if (acc && dec.illegal && illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end
  assign alu_op    = b0.alu_op;
  assign shamt     = b0.shamt;
  assign rs        = b0.rs;
  assign rt        = b0.rt;
  assign rd        = b0.rd;
  assign imm       = b0.imm;
  assign use_imm   = b0.use_imm;
  assign reg_write = b0.reg_write;
  assign illegal   = b0.illegal;
endmodule

// File: doc/alu_op_decode_stage.md
Name: alu_op_decode_stage

Overview:
- Pipelined decode stage that converts 32-bit MIPS instruction words into the ALU command bundle consumed by the ALU: op_code, shamt and operand-select/writeback controls.
- Sits between instruction fetch and the register-read/execute stage.
- Uses valid/ready handshakes on both sides, with a 2-entry output skid buffer so backpressure never drops an instruction.
- Supports a flush for branch/jump redirect.

Parameters:
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard buffered and incoming instruction this cycle.
- in_valid  in  1  instr is valid.
- in_ready  out  1  stage can accept instr this cycle.
- instr  in  32  MIPS instruction word.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- alu_op  out  5  ALU op_code: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 nor, 7 slt, 8 sll, 9 srl, 10 sra, 11 jr, 12 nop.
- shamt  out  5  instr[10:6] for sll/srl/sra; 0 otherwise.
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  writeback register: instr[15:11] for R-type, instr[20:16] for I-type, 0 for nop/jr/illegal.
- imm  out  32  immediate, sign- or zero-extended per opcode; 0 for R-type.
- use_imm  out  1  ALU operand 2 is imm rather than rt.
- reg_write  out  1  result is written back; 0 for nop/jr/illegal and whenever rd==0.
- illegal  out  1  unsupported encoding; alu_op forced to 12.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - buffer empty, out_valid=0, in_ready=1.
  - all bundle outputs 0 except alu_op=12.
  - illegal_cnt=0.
- Handshake:
  - Transfer occurs when valid&&ready.
  - out bundle must hold stable while out_valid&&!out_ready.
  - in_ready is registered: 1 iff buffer occupancy < 2.
- Latency: instruction accepted in cycle N appears on out_valid in cycle N+1 when the buffer was empty. Decode is combinational on instr; the result is written into the buffer.
- Buffer states:
  - EMPTY: accept → ONE.
  - ONE: accept without drain → FULL; drain without accept → EMPTY; accept and drain together → ONE.
  - FULL: in_ready=0; drain → ONE.
  - Order is strictly FIFO.
- flush=1:
  - Next state is EMPTY, out_valid=0, regardless of in_valid or out_ready.
  - Instruction presented in the same cycle is dropped and not counted.
  - illegal_cnt is not cleared.
- R-type decode (opcode 0), funct to alu_op:
  - 0x20→0, 0x21→1, 0x22→2, 0x23→3, 0x24→4, 0x25→5, 0x27→6, 0x2A→7, 0x00→8, 0x02→9, 0x03→10, 0x08→11.
  - Any other funct → illegal.
  - instr==0x00000000 → nop (12), not sll.
- I-type decode (use_imm=1):
  - addi 0x08→0, sign-ext.
  - addiu 0x09→1, sign-ext.
  - slti 0x0A→7, sign-ext.
  - andi 0x0C→4, zero-ext.
  - ori 0x0D→5, zero-ext.
  - Other opcodes → illegal.
- illegal_cnt increments on accepted illegal instructions only; it saturates at all-ones.
- Reset asserted mid-stream overrides flush and any handshake.

Decomposition:
- Shared package holds:
  - ALU op_code localparams: ALU_ADD…ALU_NOP = 0…12.
  - MIPS opcode/funct constants.
  - Bundle width constant.
- Natural sub-module: mips_alu_op_lut, purely combinational instr → bundle, reusable by the ALU bench.
- Skid buffer and counter stay in the top module.

Test Plan:
- Reset, then instr=0x012A4020 (add $8,$9,$10) with out_ready=1 → next cycle: out_valid=1, alu_op=0, rs=9, rt=10, rd=8, use_imm=0, reg_write=1.
- instr=0x00021883 (sra $3,$2,2) → alu_op=10, shamt=2, rd=3. Then instr=0x00000000 → alu_op=12, reg_write=0, illegal=0.
- instr=0x2128FFFF (addi $8,$9,-1) → alu_op=0, imm=0xFFFFFFFF, use_imm=1. Then instr=0x3528FFFF (ori) → alu_op=5, imm=0x0000FFFF.
- out_ready=0, push 3 instructions back-to-back:
  - in_ready drops after the 2nd.
  - 3rd is held by the producer.
  - Release out_ready → all 3 emerge in order, no duplicates.
- FULL buffer, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed instruction never appears.
- Feed 3 instructions with opcode 0x3F → each illegal=1, alu_op=12; illegal_cnt=3. With CNT_W=2, a 4th leaves illegal_cnt at 3 (saturated).
